// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of a single SPI byte controller.
// Round-robin grant, bus locking across multi-byte transactions, per-requester divider.
module spi_arbiter #(
    parameter logic [1:0]      DEFAULT_DIV = 2'd2,
    localparam int unsigned    DATA_W      = 8,
    localparam int unsigned    DIV_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              dc0,
    input  logic              dc1,
    input  logic              end0,
    input  logic              end1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              cfg_wr0,
    input  logic              cfg_wr1,
    input  logic [DIV_W-1:0]  cfg_div0,
    input  logic [DIV_W-1:0]  cfg_div1,
    output logic              spi_start,
    output logic              spi_dc,
    output logic              spi_end_txn,
    output logic              spi_set_config,
    output logic [DATA_W-1:0] spi_data_in,
    output logic [DIV_W-1:0]  spi_divider,
    input  logic [DATA_W-1:0] spi_data_out,
    input  logic              spi_busy,
    output logic [1:0]        owner
);

    typedef enum logic [2:0] {IDLE, CONFIG, ISSUE, BUSY, HOLD} state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                ptr_q, ptr_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic [DIV_W-1:0]    cur_div_q, cur_div_d;
    logic [DIV_W-1:0]    div0_q, div0_d, div1_q, div1_d;
    logic [DIV_W-1:0]    lat_div_q, lat_div_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic                lat_dc_q, lat_dc_d, lat_end_q, lat_end_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                start_q, start_d, setcfg_q, setcfg_d;
    logic                busy_arm_q, busy_arm_d;
    logic                take, sel;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 2'b00;
            ptr_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            cur_div_q   <= DEFAULT_DIV;
            div0_q      <= DEFAULT_DIV;
            div1_q      <= DEFAULT_DIV;
            lat_div_q   <= DEFAULT_DIV;
            lat_data_q  <= '0;
            lat_dc_q    <= 1'b0;
            lat_end_q   <= 1'b0;
            rdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            start_q     <= 1'b0;
            setcfg_q    <= 1'b0;
            busy_arm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cfg_valid_q <= cfg_valid_d;
            cur_div_q   <= cur_div_d;
            div0_q      <= div0_d;
            div1_q      <= div1_d;
            lat_div_q   <= lat_div_d;
            lat_data_q  <= lat_data_d;
            lat_dc_q    <= lat_dc_d;
            lat_end_q   <= lat_end_d;
            rdata_q     <= rdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            start_q     <= start_d;
            setcfg_q    <= setcfg_d;
            busy_arm_q  <= busy_arm_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cfg_valid_d = cfg_valid_q;
        cur_div_d   = cur_div_q;
        div0_d      = cfg_wr0 ? cfg_div0 : div0_q;
        div1_d      = cfg_wr1 ? cfg_div1 : div1_q;
        lat_div_d   = lat_div_q;
        lat_data_d  = lat_data_q;
        lat_dc_d    = lat_dc_q;
        lat_end_d   = lat_end_q;
        rdata_d     = rdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        start_d     = 1'b0;
        setcfg_d    = 1'b0;
        busy_arm_d  = 1'b0;
        take        = 1'b0;
        sel         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    take = 1'b1;
                    sel  = (req0 && req1) ? ptr_q : req1;
                    if (req0 && req1) ptr_d = ~sel;
                    owner_d = sel ? 2'b10 : 2'b01;
                    // Snapshot the pre-write divider so a same-cycle cfg write waits for the next grant
                    lat_div_d = sel ? div1_q : div0_q;
                    state_d = (!cfg_valid_q || lat_div_d != cur_div_q) ? CONFIG : ISSUE;
                end
            end
            CONFIG: begin
                setcfg_d    = 1'b1;
                cur_div_d   = lat_div_q;
                cfg_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                // spi_busy is not yet valid in the cycle spi_start is presented
                busy_arm_d = 1'b1;
                if (busy_arm_q && !spi_busy) begin
                    rdata_d   = spi_data_out;
                    rvalid0_d = owner_q[0];
                    rvalid1_d = owner_q[1];
                    if (lat_end_q) begin
                        owner_d = 2'b00;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                sel = owner_q[1];
                if (sel ? req1 : req0) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            lat_data_d = sel ? data1 : data0;
            lat_dc_d   = sel ? dc1 : dc0;
            lat_end_d  = sel ? end1 : end0;
            ack0_d     = ~sel;
            ack1_d     = sel;
        end
    end

    assign owner          = owner_q;
    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rvalid0        = rvalid0_q;
    assign rvalid1        = rvalid1_q;
    assign rdata          = rdata_q;
    assign spi_start      = start_q;
    assign spi_set_config = setcfg_q;
    assign spi_data_in    = lat_data_q;
    assign spi_dc         = lat_dc_q;
    assign spi_end_txn    = lat_end_q;
    assign spi_divider    = cur_div_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural SPI controller and a queue scoreboard.
module tb_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, dc0, dc1, end0, end1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       cfg_wr0, cfg_wr1;
    logic [1:0] cfg_div0, cfg_div1;
    logic       spi_start, spi_dc, spi_end_txn, spi_set_config;
    logic [7:0] spi_data_in;
    logic [1:0] spi_divider;
    logic [7:0] spi_data_out;
    logic       spi_busy;
    logic [1:0] owner;

    spi_arbiter #(.DEFAULT_DIV(2'd2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .dc0(dc0), .dc1(dc1), .end0(end0), .end1(end1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .cfg_wr0(cfg_wr0), .cfg_wr1(cfg_wr1), .cfg_div0(cfg_div0), .cfg_div1(cfg_div1),
        .spi_start(spi_start), .spi_dc(spi_dc), .spi_end_txn(spi_end_txn),
        .spi_set_config(spi_set_config), .spi_data_in(spi_data_in),
        .spi_divider(spi_divider), .spi_data_out(spi_data_out), .spi_busy(spi_busy),
        .owner(owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = 0, cfg_cyc = 0, start_cyc = 0;
    bit hang = 1'b0;
    int busy_cnt;

    int         exp_grant[$];
    logic [1:0] exp_cfg[$];
    logic [9:0] exp_start[$];
    logic [8:0] exp_rx[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: busy for four cycles after start, returns the byte XOR 8'h99
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_busy     <= 1'b0;
            spi_data_out <= 8'h00;
            busy_cnt     <= 0;
        end else if (spi_start) begin
            spi_busy     <= 1'b1;
            spi_data_out <= spi_data_in ^ 8'h99;
            busy_cnt     <= 3;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1 && !hang) begin
            busy_cnt <= 0;
            spi_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_byte(input int id, input logic [7:0] d, input logic dc, input logic e,
                            input bit cfg, input logic [1:0] div, input bit rx);
        logic b;
        b = (id != 0);
        exp_grant.push_back(id);
        if (cfg) exp_cfg.push_back(div);
        exp_start.push_back({e, dc, d});
        if (rx) exp_rx.push_back({b, d ^ 8'h99});
    endtask

    task automatic drive(input int id, input logic [7:0] d, input logic dc, input logic e);
        if (id == 0) begin req0 = 1'b1; data0 = d; dc0 = dc; end0 = e; end
        else         begin req1 = 1'b1; data1 = d; dc1 = dc; end1 = e; end
    endtask

    task automatic wait_ack(input int id);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!(id != 0 ? ack1 : ack0) && n < 200);
        chk($sformatf("ack%0d_seen", id), 32'(id != 0 ? ack1 : ack0), 1);
    endtask

    task automatic wait_rv(input int id);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!(id != 0 ? rvalid1 : rvalid0) && n < 200);
        chk($sformatf("rvalid%0d_seen", id), 32'(id != 0 ? rvalid1 : rvalid0), 1);
    endtask

    // Scoreboard monitor
    int         m_id, m_e;
    logic [1:0] m_div;
    logic [9:0] m_s;
    logic [8:0] m_r;
    always @(negedge clk) begin
        if (!rst) begin
            if (ack0 || ack1) begin
                chk("ack_exclusive", 32'(ack0 & ack1), 0);
                m_id = ack1 ? 1 : 0;
                ack_cyc = cyc;
                if (exp_grant.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL unexpected_ack: observed ack%0d expected none", m_id);
                end else begin
                    m_e = exp_grant.pop_front();
                    chk("grant_id", 32'(m_id), 32'(m_e));
                    chk("owner_at_ack", 32'(owner), m_e != 0 ? 2 : 1);
                end
            end
            if (spi_set_config) begin
                cfg_cyc = cyc;
                if (exp_cfg.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL unexpected_config: observed div %0d expected none", spi_divider);
                end else begin
                    m_div = exp_cfg.pop_front();
                    chk("config_div", 32'(spi_divider), 32'(m_div));
                end
            end
            if (spi_start) begin
                start_cyc = cyc;
                if (exp_start.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL unexpected_start: observed %0h expected none", spi_data_in);
                end else begin
                    m_s = exp_start.pop_front();
                    chk("start_payload", 32'({spi_end_txn, spi_dc, spi_data_in}), 32'(m_s));
                end
            end
            if (rvalid0 || rvalid1) begin
                chk("rvalid_exclusive", 32'(rvalid0 & rvalid1), 0);
                if (exp_rx.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL unexpected_rvalid: observed rvalid%0d expected none", rvalid1);
                end else begin
                    m_r = exp_rx.pop_front();
                    chk("rvalid_id", 32'(rvalid1), 32'(m_r[8]));
                    chk("rdata", 32'(rdata), 32'(m_r[7:0]));
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        {req0, req1, dc0, dc1, end0, end1, cfg_wr0, cfg_wr1} = '0;
        data0 = 8'h00; data1 = 8'h00; cfg_div0 = 2'd0; cfg_div1 = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_acks", 32'({ack0, ack1}), 0);
        chk("rst_rvalids", 32'({rvalid0, rvalid1}), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_divider", 32'(spi_divider), 2);
        chk("rst_strobes", 32'({spi_start, spi_set_config}), 0);
        chk("rst_spi_data", 32'({spi_dc, spi_end_txn, spi_data_in}), 0);
        rst = 1'b0;
        @(negedge clk);

        // First grant after reset goes through CONFIG
        exp_byte(0, 8'hA5, 1'b1, 1'b1, 1, 2'd2, 1);
        drive(0, 8'hA5, 1'b1, 1'b1);
        wait_ack(0); req0 = 1'b0;
        wait_rv(0);
        chk("first_cfg_latency", 32'(cfg_cyc - ack_cyc), 1);
        chk("first_start_latency", 32'(start_cyc - ack_cyc), 2);
        chk("first_rdata", 32'(rdata), 'h3C);
        chk("first_owner_released", 32'(owner), 0);

        // Same divider: straight to ISSUE
        exp_byte(0, 8'h11, 1'b0, 1'b1, 0, 2'd0, 1);
        drive(0, 8'h11, 1'b0, 1'b1);
        wait_ack(0); req0 = 1'b0;
        wait_rv(0);
        chk("nocfg_start_latency", 32'(start_cyc - ack_cyc), 1);

        // Contention with both requests held: 0, 1, 0
        exp_byte(0, 8'h20, 1'b0, 1'b1, 0, 2'd0, 1);
        exp_byte(1, 8'h40, 1'b1, 1'b1, 0, 2'd0, 1);
        exp_byte(0, 8'h21, 1'b0, 1'b1, 0, 2'd0, 1);
        drive(0, 8'h20, 1'b0, 1'b1);
        drive(1, 8'h40, 1'b1, 1'b1);
        wait_ack(0); data0 = 8'h21;
        wait_ack(1); req1 = 1'b0;
        wait_ack(0); req0 = 1'b0;
        wait_rv(0);

        // Locking: three-byte transaction from 0 while 1 waits
        exp_byte(0, 8'h01, 1'b0, 1'b0, 0, 2'd0, 1);
        exp_byte(0, 8'h02, 1'b0, 1'b0, 0, 2'd0, 1);
        exp_byte(0, 8'h03, 1'b0, 1'b1, 0, 2'd0, 1);
        exp_byte(1, 8'h55, 1'b0, 1'b1, 0, 2'd0, 1);
        drive(0, 8'h01, 1'b0, 1'b0);
        drive(1, 8'h55, 1'b0, 1'b1);
        wait_ack(0); data0 = 8'h02;
        wait_ack(0); data0 = 8'h03; end0 = 1'b1;
        wait_ack(0); req0 = 1'b0;
        wait_ack(1); req1 = 1'b0;
        wait_rv(1);
        chk("lock_owner_released", 32'(owner), 0);

        // Divider write for 1 while 0 owns: only 1's next grant reconfigures
        exp_byte(0, 8'h66, 1'b0, 1'b0, 0, 2'd0, 1);
        exp_byte(0, 8'h67, 1'b0, 1'b1, 0, 2'd0, 1);
        exp_byte(1, 8'h77, 1'b1, 1'b1, 1, 2'd1, 1);
        drive(0, 8'h66, 1'b0, 1'b0);
        wait_ack(0);
        cfg_wr1 = 1'b1; cfg_div1 = 2'd1;
        @(negedge clk);
        cfg_wr1 = 1'b0; data0 = 8'h67; end0 = 1'b1;
        wait_ack(0); req0 = 1'b0;
        wait_rv(0);
        drive(1, 8'h77, 1'b1, 1'b1);
        wait_ack(1); req1 = 1'b0;
        wait_rv(1);
        chk("div1_cfg_latency", 32'(cfg_cyc - ack_cyc), 1);
        chk("div1_applied", 32'(spi_divider), 1);

        // Reset while the controller is busy: byte dropped, no rvalid
        exp_byte(1, 8'h99, 1'b0, 1'b1, 0, 2'd0, 0);
        hang = 1'b1;
        drive(1, 8'h99, 1'b0, 1'b1);
        wait_ack(1); req1 = 1'b0;
        n = 0;
        while (!spi_busy && n < 50) begin @(negedge clk); n++; end
        chk("busy_before_reset", 32'(spi_busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_owner", 32'(owner), 0);
        chk("midrst_rvalid", 32'({rvalid0, rvalid1}), 0);
        chk("midrst_divider", 32'(spi_divider), 2);
        @(negedge clk);
        rst = 1'b0; hang = 1'b0;
        repeat (10) @(negedge clk);
        chk("postrst_owner", 32'(owner), 0);

        // First request after reset reconfigures with the reset divider
        exp_byte(1, 8'hAB, 1'b0, 1'b1, 1, 2'd2, 1);
        drive(1, 8'hAB, 1'b0, 1'b1);
        wait_ack(1); req1 = 1'b0;
        wait_rv(1);
        chk("postrst_cfg_latency", 32'(cfg_cyc - ack_cyc), 1);
        chk("postrst_start_latency", 32'(start_cyc - ack_cyc), 2);

        repeat (5) @(negedge clk);
        chk("grant_queue_drained", 32'(exp_grant.size()), 0);
        chk("cfg_queue_drained", 32'(exp_cfg.size()), 0);
        chk("start_queue_drained", 32'(exp_start.size()), 0);
        chk("rx_queue_drained", 32'(exp_rx.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 2'd2, the divider value recorded as applied after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports req0/req1, input, 1, requester n wants to send a byte.
REQ-005 SHALL have ports data0/data1, input, 8, byte to send.
REQ-006 SHALL have ports dc0/dc1 and end0/end1, input, 1 each: D/C level; last byte of the transaction.
REQ-007 SHALL have ports ack0/ack1, output, 1, one-cycle pulse when the byte is latched.
REQ-008 SHALL have ports rvalid0/rvalid1, output, 1, one-cycle pulse when rdata holds the received byte.
REQ-009 SHALL have port rdata, output, 8, last received byte, shared by both requesters.
REQ-010 SHALL have ports cfg_wr0/cfg_wr1, input, 1, and cfg_div0/cfg_div1, input, 2: write requester n's private divider register.
REQ-011 SHALL have ports spi_start, spi_dc, spi_end_txn, spi_set_config (output, 1), spi_data_in (output, 8) and spi_divider (output, 2), driving the SPI controller.
REQ-012 SHALL have ports spi_data_out (input, 8) and spi_busy (input, 1), fed from the SPI controller.
REQ-013 SHALL have port owner, output, 2: 00 none, 01 requester 0, 10 requester 1; 11 never occurs.

Function
REQ-014 SHALL implement FSM states IDLE, CONFIG, ISSUE, BUSY, HOLD.
REQ-015 SHALL, in IDLE, grant a single requester:
- Sole requester wins.
- If both request, the round-robin pointer picks the winner; the pointer then moves to the loser.
REQ-016 SHALL, in the grant cycle:
- Latch the winner's data, dc and end.
- Pulse the winner's ack.
- Set owner.
REQ-017 SHALL go from grant to CONFIG if cfg_valid=0 or the winner's divider differs from cur_div; otherwise go to ISSUE.
REQ-018 SHALL, in CONFIG, assert spi_set_config for one cycle, drive spi_divider with the owner's divider, update cur_div, set cfg_valid, then go to ISSUE.
REQ-019 SHALL, in ISSUE, assert spi_start for exactly one cycle with latched data/dc/end on spi_data_in/spi_dc/spi_end_txn, then go to BUSY.
REQ-020 SHALL ignore spi_busy in the first BUSY cycle; from the second cycle on, spi_busy=0 ends the byte.
REQ-021 SHALL, at byte end:
- Load rdata from spi_data_out.
- Pulse the owner's rvalid in the following cycle.
- Go to IDLE with owner=00 if latched end=1, else go to HOLD.
REQ-022 SHALL, in HOLD, serve only the owner:
- The other requester is ignored indefinitely.
- When the owner's req=1: latch, pulse ack, go to ISSUE with no CONFIG and no arbitration.
REQ-023 SHALL write the divider register on cfg_wrn at any time; a write takes effect at that requester's next grant, never mid-transaction.
REQ-024 SHALL, when cfg_wrn coincides with that requester's grant, compare the pre-write divider value.
REQ-025 SHALL assert ack0 and ack1 in the same cycle never, and rvalid0 and rvalid1 in the same cycle never.
REQ-026 SHALL meet these latencies from req in IDLE:
- ack at cycle 0.
- spi_start at cycle 1 without CONFIG, cycle 2 with CONFIG.
REQ-027 SHALL keep spi_start, spi_set_config, ack and rvalid at 0 in every state not named above.

Reset
REQ-028 SHALL, while rst=1, immediately force:
- State IDLE, owner=00, pointer at requester 0.
- cfg_valid=0, cur_div=DEFAULT_DIV.
- Both divider registers=DEFAULT_DIV, rdata=0.
- All pulse outputs 0; spi_data_in, spi_dc, spi_end_txn = 0; spi_divider=DEFAULT_DIV.
REQ-029 SHALL, on reset mid-transaction, drop any in-flight byte without an rvalid, and the first grant after reset SHALL pass through CONFIG.

Verification
REQ-030 SHALL cover first grant: reset, req0 with data0=8'hA5, end0=1 -> ack0 at cycle 0, spi_set_config with spi_divider=2 at cycle 1, spi_start with spi_data_in=8'hA5 at cycle 2; spi_busy falls with spi_data_out=8'h3C -> rvalid0 with rdata=8'h3C, owner=00.
REQ-031 SHALL cover contention: req0 and req1 rise together twice, each single-byte (end=1) -> first grant to 0, second to 1, third to 0.
REQ-032 SHALL cover locking: requester 0 sends 3 bytes (end0=0,0,1) while req1 is held high -> no ack1 until owner returns to 00, then requester 1 is granted.
REQ-033 SHALL cover divider change: cfg_wr1 with cfg_div1=1 while requester 0 owns -> requester 0 gets no CONFIG; requester 1's next grant emits spi_set_config with spi_divider=1.
REQ-034 SHALL cover reset in BUSY: rst pulsed while spi_busy=1 -> no rvalid, owner=00; the next request passes through CONFIG.
